// File: rtl/if_id_pkg.sv
// -----------------------------------------------------------------------------
// if_id_pkg
//   Shared definitions for the IF->ID skid stage: the default bubble
//   instruction, the occupancy FSM state encoding and a helper that maps a
//   state to the number of entries it holds.
// -----------------------------------------------------------------------------
package if_id_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    function automatic logic [1:0] entries_held(state_e s);
        unique case (s)
            StOne:   return 2'd1;
            StFull:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/if_id_entry.sv
// -----------------------------------------------------------------------------
// if_id_entry
//   One LANES-wide storage slot holding per-lane pc, inst and lane_valid.
//   Lanes written with d_lane_valid=0 are stored as bubbles (pc=0, NOP), so
//   an invalid lane never carries stale data.
// Ports
//   clk, reset      clock, synchronous active-high reset (clears to bubble)
//   load            capture d_* (with per-lane bubble masking)
//   clear           overwrite with bubbles; wins over load
//   d_lane_valid    per-lane valid of incoming data
//   d_pc, d_inst    incoming lane data, lane i at [i*W +: W]
//   q_lane_valid    stored per-lane valid
//   q_pc, q_inst    stored lane data
// -----------------------------------------------------------------------------
module if_id_entry
    import if_id_pkg::*;
#(
    parameter int unsigned     LANES    = 2,
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     ILEN     = 32,
    parameter logic [ILEN-1:0] NOP_INST = ILEN'(NOP_INST_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  clear,
    input  logic [LANES-1:0]      d_lane_valid,
    input  logic [LANES*XLEN-1:0] d_pc,
    input  logic [LANES*ILEN-1:0] d_inst,
    output logic [LANES-1:0]      q_lane_valid,
    output logic [LANES*XLEN-1:0] q_pc,
    output logic [LANES*ILEN-1:0] q_inst
);

    localparam logic [LANES*ILEN-1:0] BUBBLE_INST = {LANES{NOP_INST}};

    logic [LANES-1:0]      lv_q;
    logic [LANES*XLEN-1:0] pc_q, pc_masked;
    logic [LANES*ILEN-1:0] inst_q, inst_masked;

    always_comb begin
        pc_masked   = '0;
        inst_masked = BUBBLE_INST;
        for (int i = 0; i < int'(LANES); i++) begin
            if (d_lane_valid[i]) begin
                pc_masked[i*XLEN +: XLEN]   = d_pc[i*XLEN +: XLEN];
                inst_masked[i*ILEN +: ILEN] = d_inst[i*ILEN +: ILEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lv_q   <= '0;
            pc_q   <= '0;
            inst_q <= BUBBLE_INST;
        end else if (load) begin
            lv_q   <= d_lane_valid;
            pc_q   <= pc_masked;
            inst_q <= inst_masked;
        end
    end

    assign q_lane_valid = lv_q;
    assign q_pc         = pc_q;
    assign q_inst       = inst_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// -----------------------------------------------------------------------------
// if_id_skid_stage
//   IF->ID pipeline stage carrying LANES (pc, inst) pairs over a valid/ready
//   handshake. A main entry (M) drives the outputs and a skid entry (S)
//   catches one extra entry so that in_ready depends only on registered state.
//   Supports flush, per-lane kill with NOP bubbles and a saturating
//   backpressure cycle counter.
// Ports
//   clk, reset          clock, synchronous active-high reset
//   flush               discard held and incoming entries
//   in_valid/in_ready   fetch-side handshake (in_ready = !skid occupied)
//   in_lane_valid       per-lane valid; an offer with all lanes 0 is ignored
//   in_pc, in_inst      offered lanes, lane i at [i*W +: W]
//   out_valid/out_ready decode-side handshake
//   out_lane_valid      per-lane valid of presented entry (0 when !out_valid)
//   out_pc, out_inst    presented lanes (bubbles when !out_valid)
//   occupancy           entries held (0..2), registered
//   stall_cycles        saturating count of out_valid & !out_ready cycles
// -----------------------------------------------------------------------------
module if_id_skid_stage
    import if_id_pkg::*;
#(
    parameter int unsigned     LANES    = 2,
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     ILEN     = 32,
    parameter logic [ILEN-1:0] NOP_INST = ILEN'(NOP_INST_DEFAULT),
    parameter int unsigned     CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      in_lane_valid,
    input  logic [LANES*XLEN-1:0] in_pc,
    input  logic [LANES*ILEN-1:0] in_inst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_lane_valid,
    output logic [LANES*XLEN-1:0] out_pc,
    output logic [LANES*ILEN-1:0] out_inst,
    output logic [1:0]            occupancy,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam logic [LANES*ILEN-1:0] BUBBLE_INST = {LANES{NOP_INST}};

    state_e state_q, state_d;
    logic   in_fire, out_fire;
    logic   m_load, m_clear, m_from_s, s_load, s_clear;

    logic [LANES-1:0]      m_d_lv, m_lv, s_lv;
    logic [LANES*XLEN-1:0] m_d_pc, m_pc, s_pc;
    logic [LANES*ILEN-1:0] m_d_inst, m_inst, s_inst;

    logic [1:0]       occ_q;
    logic [CNT_W-1:0] stall_q;

    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign in_fire   = in_valid & in_ready & (|in_lane_valid);
    assign out_fire  = out_valid & out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: if (in_fire) state_d = StOne;
                StOne: begin
                    if (in_fire && !out_fire)      state_d = StFull;
                    else if (!in_fire && out_fire) state_d = StEmpty;
                end
                StFull:  if (out_fire) state_d = StOne;
                default: state_d = StEmpty;
            endcase
        end
    end

    // Entry load/clear controls
    always_comb begin
        m_load   = 1'b0;
        m_clear  = 1'b0;
        m_from_s = 1'b0;
        s_load   = 1'b0;
        s_clear  = 1'b0;
        if (flush) begin
            m_clear = 1'b1;
            s_clear = 1'b1;
        end else begin
            unique case (state_q)
                StEmpty: m_load = in_fire;
                StOne: begin
                    m_load  = in_fire & out_fire;
                    s_load  = in_fire & ~out_fire;
                    m_clear = ~in_fire & out_fire;
                end
                StFull: begin
                    m_load   = out_fire;
                    m_from_s = out_fire;
                    s_clear  = out_fire;
                end
                default: ;
            endcase
        end
    end

    assign m_d_lv   = m_from_s ? s_lv   : in_lane_valid;
    assign m_d_pc   = m_from_s ? s_pc   : in_pc;
    assign m_d_inst = m_from_s ? s_inst : in_inst;

    if_id_entry #(
        .LANES    (LANES),
        .XLEN     (XLEN),
        .ILEN     (ILEN),
        .NOP_INST (NOP_INST)
    ) u_main (
        .clk          (clk),
        .reset        (reset),
        .load         (m_load),
        .clear        (m_clear),
        .d_lane_valid (m_d_lv),
        .d_pc         (m_d_pc),
        .d_inst       (m_d_inst),
        .q_lane_valid (m_lv),
        .q_pc         (m_pc),
        .q_inst       (m_inst)
    );

    if_id_entry #(
        .LANES    (LANES),
        .XLEN     (XLEN),
        .ILEN     (ILEN),
        .NOP_INST (NOP_INST)
    ) u_skid (
        .clk          (clk),
        .reset        (reset),
        .load         (s_load),
        .clear        (s_clear),
        .d_lane_valid (in_lane_valid),
        .d_pc         (in_pc),
        .d_inst       (in_inst),
        .q_lane_valid (s_lv),
        .q_pc         (s_pc),
        .q_inst       (s_inst)
    );

    // M is already bubble-filled when empty; masking keeps outputs clean regardless
    assign out_lane_valid = out_valid ? m_lv   : '0;
    assign out_pc         = out_valid ? m_pc   : '0;
    assign out_inst       = out_valid ? m_inst : BUBBLE_INST;

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q   <= 2'd0;
            stall_q <= '0;
        end else begin
            occ_q <= entries_held(state_d);
            if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign occupancy    = occ_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_if_id_skid_stage.sv
module tb_if_id_skid_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [1:0]  in_lane_valid;
    logic [63:0] in_pc;
    logic [63:0] in_inst;
    logic        out_ready;

    logic        in_ready, out_valid;
    logic [1:0]  out_lane_valid, occupancy;
    logic [63:0] out_pc, out_inst;
    logic [15:0] stall_cycles;

    logic        c_in_ready, c_out_valid;
    logic [1:0]  c_out_lane_valid, c_occupancy;
    logic [63:0] c_out_pc, c_out_inst;
    logic [2:0]  c_stall_cycles;

    if_id_skid_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_lane_valid(in_lane_valid),
        .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane_valid(out_lane_valid),
        .out_pc(out_pc), .out_inst(out_inst),
        .occupancy(occupancy), .stall_cycles(stall_cycles)
    );

    if_id_skid_stage #(.CNT_W(3)) dut_c (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(c_in_ready), .in_lane_valid(in_lane_valid),
        .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_lane_valid(c_out_lane_valid),
        .out_pc(c_out_pc), .out_inst(c_out_inst),
        .occupancy(c_occupancy), .stall_cycles(c_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  lv;
        logic [63:0] pc;
        logic [63:0] inst;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t mk_exp(logic [1:0] lv, logic [63:0] pc, logic [63:0] inst);
        exp_t e;
        e.lv   = lv;
        e.pc   = {lv[1] ? pc[63:32] : 32'h0, lv[0] ? pc[31:0] : 32'h0};
        e.inst = {lv[1] ? inst[63:32] : NOP, lv[0] ? inst[31:0] : NOP};
        return e;
    endfunction

    task automatic set_in(input logic iv, input logic [1:0] lv, input logic [31:0] base,
                          input logic ordy, input logic fl);
        logic [31:0] pc1;
        pc1           = base + 32'd4;
        in_valid      = iv;
        in_lane_valid = lv;
        in_pc         = {pc1, base};
        in_inst       = {32'hA000_0000 | pc1, 32'hA000_0000 | base};
        out_ready     = ordy;
        flush         = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: occupancy, stall count and in-order scoreboard
    bit   mon_en = 1'b0;
    int   occ_m  = 0;
    int   stall_m = 0;
    exp_t e_pop;
    bit   fi, fo;

    always @(negedge clk) begin
        if (mon_en) begin
            check("in_ready", {63'b0, in_ready}, {63'b0, occ_m != 2});
            check("out_valid", {63'b0, out_valid}, {63'b0, occ_m != 0});
            check("occupancy", {62'b0, occupancy}, 64'(occ_m));
            check("stall_cycles", {48'b0, stall_cycles}, 64'(stall_m));
            check("c_occupancy", {62'b0, c_occupancy}, 64'(occ_m));
            check("c_in_ready", {63'b0, c_in_ready}, {63'b0, occ_m != 2});
            check("c_out_valid", {63'b0, c_out_valid}, {63'b0, occ_m != 0});
            if (occ_m == 0) begin
                check("idle_lane_valid", {62'b0, out_lane_valid}, 64'h0);
                check("idle_pc", out_pc, 64'h0);
                check("idle_inst", out_inst, {NOP, NOP});
                check("c_idle_lane_valid", {62'b0, c_out_lane_valid}, 64'h0);
                check("c_idle_pc", c_out_pc, 64'h0);
                check("c_idle_inst", c_out_inst, {NOP, NOP});
            end
            if (reset) begin
                occ_m   = 0;
                stall_m = 0;
                sb.delete();
            end else begin
                if (occ_m != 0 && !out_ready && stall_m != 65535) stall_m++;
                if (flush) begin
                    occ_m = 0;
                    sb.delete();
                end else begin
                    fo = (occ_m != 0) && out_ready;
                    fi = in_valid && (occ_m != 2) && (|in_lane_valid);
                    if (fo) begin
                        if (sb.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL sb_underflow: got out_fire, expected no entry held");
                        end else begin
                            e_pop = sb.pop_front();
                            check("sb_lane_valid", {62'b0, out_lane_valid}, {62'b0, e_pop.lv});
                            check("sb_pc", out_pc, e_pop.pc);
                            check("sb_inst", out_inst, e_pop.inst);
                        end
                    end
                    if (fi) sb.push_back(mk_exp(in_lane_valid, in_pc, in_inst));
                    occ_m = occ_m + int'(fi) - int'(fo);
                end
            end
        end
    end

    typedef struct {
        logic        iv;
        logic [1:0]  lv;
        logic [31:0] base;
        logic        ordy;
        logic        fl;
        logic [1:0]  exp_occ;
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic [1:0]  exp_olv;
    } vec_t;

    vec_t vecs[18];

    initial begin
        // stream
        vecs[0]  = '{1'b1, 2'b11, 32'h100, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 2'b11};
        vecs[1]  = '{1'b1, 2'b11, 32'h108, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 2'b11};
        vecs[2]  = '{1'b1, 2'b11, 32'h110, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 2'b11};
        vecs[3]  = '{1'b0, 2'b11, 32'h000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'b00};
        // backpressure, third offer held off, then drain in order
        vecs[4]  = '{1'b1, 2'b11, 32'h200, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 2'b11};
        vecs[5]  = '{1'b1, 2'b11, 32'h208, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 2'b11};
        vecs[6]  = '{1'b1, 2'b11, 32'h210, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 2'b11};
        vecs[7]  = '{1'b0, 2'b11, 32'h000, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 2'b11};
        vecs[8]  = '{1'b0, 2'b11, 32'h000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'b00};
        // flush in FULL with an offer present
        vecs[9]  = '{1'b1, 2'b11, 32'h500, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 2'b11};
        vecs[10] = '{1'b1, 2'b11, 32'h508, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 2'b11};
        vecs[11] = '{1'b1, 2'b11, 32'h300, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'b00};
        // flush in ONE drops a same-cycle in_fire
        vecs[12] = '{1'b1, 2'b11, 32'h600, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 2'b11};
        vecs[13] = '{1'b1, 2'b11, 32'h300, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'b00};
        // all-lanes-0 offer ignored, single upper lane passes
        vecs[14] = '{1'b1, 2'b00, 32'h700, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'b00};
        vecs[15] = '{1'b1, 2'b10, 32'h800, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 2'b10};
        vecs[16] = '{1'b0, 2'b11, 32'h000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'b00};
        vecs[17] = '{1'b1, 2'b11, 32'h900, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 2'b11};

        // reset with in_valid asserted
        reset = 1'b1;
        set_in(1'b1, 2'b11, 32'hF00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {63'b0, in_ready}, 64'h1);
        check("rst_out_valid", {63'b0, out_valid}, 64'h0);
        check("rst_out_inst", out_inst, {NOP, NOP});
        check("rst_stall", {48'b0, stall_cycles}, 64'h0);
        check("rst_occupancy", {62'b0, occupancy}, 64'h0);
        reset = 1'b0;
        set_in(1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
        mon_en = 1'b1;

        for (int i = 0; i < 18; i++) begin
            set_in(vecs[i].iv, vecs[i].lv, vecs[i].base, vecs[i].ordy, vecs[i].fl);
            step();
            check($sformatf("vec%0d_occ", i), {62'b0, occupancy}, {62'b0, vecs[i].exp_occ});
            check($sformatf("vec%0d_in_ready", i), {63'b0, in_ready},
                  {63'b0, vecs[i].exp_in_ready});
            check($sformatf("vec%0d_out_valid", i), {63'b0, out_valid},
                  {63'b0, vecs[i].exp_out_valid});
            check($sformatf("vec%0d_out_lv", i), {62'b0, out_lane_valid},
                  {62'b0, vecs[i].exp_olv});
        end
        set_in(1'b0, 2'b00, 32'h0, 1'b1, 1'b0);
        step();

        // lane kill: upper lane becomes a bubble
        set_in(1'b1, 2'b01, 32'h400, 1'b0, 1'b0);
        step();
        set_in(1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
        check("kill_lane_valid", {62'b0, out_lane_valid}, 64'h1);
        check("kill_lane1_pc", {32'b0, out_pc[63:32]}, 64'h0);
        check("kill_lane0_pc", {32'b0, out_pc[31:0]}, 64'h400);
        check("kill_lane1_inst", {32'b0, out_inst[63:32]}, 64'h13);
        check("kill_lane0_inst", {32'b0, out_inst[31:0]}, 64'hA000_0400);
        set_in(1'b0, 2'b00, 32'h0, 1'b1, 1'b0);
        step();

        // reset in the middle of a backpressured FULL state
        set_in(1'b1, 2'b11, 32'hB00, 1'b0, 1'b0);
        step();
        set_in(1'b1, 2'b11, 32'hB08, 1'b0, 1'b0);
        step();
        check("mid_full_occ", {62'b0, occupancy}, 64'h2);
        set_in(1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_occ", {62'b0, occupancy}, 64'h0);
        check("mid_rst_stall", {48'b0, stall_cycles}, 64'h0);
        check("mid_rst_in_ready", {63'b0, in_ready}, 64'h1);
        check("mid_rst_out_valid", {63'b0, out_valid}, 64'h0);

        // counter saturation on the CNT_W=3 instance
        set_in(1'b1, 2'b11, 32'hA00, 1'b0, 1'b0);
        step();
        set_in(1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("sat_stall_k%0d", k), {61'b0, c_stall_cycles},
                  64'((k > 7) ? 7 : k));
        end
        check("wide_stall", {48'b0, stall_cycles}, 64'd10);
        set_in(1'b0, 2'b00, 32'h0, 1'b1, 1'b0);
        repeat (2) step();

        check("sb_drained", 64'(sb.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
